// File: rtl/conv_seq_pkg.sv
// Shared encodings for the conv window sequencer: FSM states, flag-bundle layout, window half-size.
package conv_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FLOAD = 3'd1;
  localparam logic [2:0] ST_FCHG  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int unsigned FLG_FIRST_ROW = 0;
  localparam int unsigned FLG_LAST_ROW  = 1;
  localparam int unsigned FLG_FIRST_COL = 2;
  localparam int unsigned FLG_LAST_COL  = 3;
  localparam int unsigned FLG_W         = 4;

  // Rows above/below the centre row in a K-row window.
  function automatic int unsigned k_half(input int unsigned k);
    return (k - 1) / 2;
  endfunction

endpackage

// File: rtl/seq_delay_line.sv
// Fixed-depth shift register that realigns sideband signals to the PE pipeline.
module seq_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_window_sequencer.sv
// Per-pass sequencer: filter load, filter swap, raster sweep with edge zero-padding,
// and pipeline-aligned edge flags / cal_start for one conv_pe.
module conv_window_sequencer
  import conv_seq_pkg::*;
#(
  parameter int unsigned K          = 3,
  parameter int unsigned IFM_DW     = 32,
  parameter int unsigned W_SIZE     = 10,
  parameter int unsigned N_FLOAD    = 4,
  parameter int unsigned W_FIDX     = 2,
  parameter int unsigned FLAG_DELAY = 2,
  parameter int unsigned CAL_LAG    = 3
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_start,
  input  logic [W_SIZE-1:0]   i_cfg_width,
  input  logic [W_SIZE-1:0]   i_cfg_height,
  input  logic                i_stall,
  output logic                o_rd_en,
  output logic [W_SIZE-1:0]   o_rd_row,
  output logic [W_SIZE-1:0]   o_rd_col,
  input  logic [K*IFM_DW-1:0] i_rd_data,
  output logic [K*IFM_DW-1:0] o_ifm_flat,
  output logic                o_vld,
  output logic                o_is_first_row,
  output logic                o_is_last_row,
  output logic                o_is_first_col,
  output logic                o_is_last_col,
  output logic                o_load_filter,
  output logic [W_FIDX-1:0]   o_load_idx,
  output logic                o_change_filter,
  output logic                o_data_run,
  output logic                o_cal_start,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned HALF      = k_half(K);
  localparam int unsigned DRAIN_LEN = 1 + CAL_LAG + FLAG_DELAY;
  localparam int unsigned DCW       = $clog2(DRAIN_LEN + 1);
  localparam int unsigned RW        = W_SIZE + 1;

  logic [2:0]          state, next_state;
  logic                armed;
  logic                issue_c;
  logic                last_pos_c;
  logic [W_SIZE-1:0]   width, height, row, col;
  logic [W_FIDX-1:0]   fidx;
  logic [DCW-1:0]      dcnt;
  logic [FLG_W-1:0]    flags_c, rd_flags, flags_dly;
  logic [K*IFM_DW-1:0] pad_c;

  assign last_pos_c = (row == height - W_SIZE'(1)) && (col == width - W_SIZE'(1));

  // Next state and issue decision.
  always_comb begin
    next_state = state;
    issue_c    = 1'b0;
    case (state)
      ST_IDLE:  if (i_start && armed) next_state = ST_FLOAD;
      ST_FLOAD: if (fidx == W_FIDX'(N_FLOAD - 1)) next_state = ST_FCHG;
      ST_FCHG:  next_state = ((width == '0) || (height == '0)) ? ST_DRAIN : ST_RUN;
      ST_RUN: begin
        if (!i_stall) begin
          issue_c = 1'b1;
          if (last_pos_c) next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: if (dcnt == DCW'(DRAIN_LEN - 1)) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Edge flags of the position being issued this cycle.
  always_comb begin
    flags_c                = '0;
    flags_c[FLG_FIRST_ROW] = (row == '0);
    flags_c[FLG_LAST_ROW]  = (row == height - W_SIZE'(1));
    flags_c[FLG_FIRST_COL] = (col == '0);
    flags_c[FLG_LAST_COL]  = (col == width - W_SIZE'(1));
  end

  // Zero window slots whose source row falls outside the frame.
  always_comb begin
    pad_c = i_rd_data;
    for (int j = 0; j < int'(K); j++) begin
      if ((({1'b0, o_rd_row} + RW'(j)) < RW'(HALF)) ||
          (({1'b0, o_rd_row} + RW'(j)) >= ({1'b0, height} + RW'(HALF))))
        pad_c[j*IFM_DW +: IFM_DW] = '0;
    end
  end

  // armed blocks an i_start coinciding with reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      armed <= 1'b0;
    end else begin
      state <= next_state;
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      width  <= '0;
      height <= '0;
      row    <= '0;
      col    <= '0;
      fidx   <= '0;
      dcnt   <= '0;
    end else begin
      if ((state == ST_IDLE) && (next_state == ST_FLOAD)) begin
        width  <= i_cfg_width;
        height <= i_cfg_height;
        row    <= '0;
        col    <= '0;
      end
      fidx <= (state == ST_FLOAD) ? fidx + W_FIDX'(1) : '0;
      dcnt <= (state == ST_DRAIN) ? dcnt + DCW'(1) : '0;
      if (issue_c) begin
        if (col == width - W_SIZE'(1)) begin
          col <= '0;
          row <= row + W_SIZE'(1);
        end else begin
          col <= col + W_SIZE'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_rd_en         <= 1'b0;
      o_rd_row        <= '0;
      o_rd_col        <= '0;
      rd_flags        <= '0;
      o_vld           <= 1'b0;
      o_ifm_flat      <= '0;
      o_load_filter   <= 1'b0;
      o_load_idx      <= '0;
      o_change_filter <= 1'b0;
      o_data_run      <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      o_rd_en  <= issue_c;
      rd_flags <= issue_c ? flags_c : '0;
      if (issue_c) begin
        o_rd_row <= row;
        o_rd_col <= col;
      end
      o_vld <= o_rd_en;
      if (o_rd_en) o_ifm_flat <= pad_c;
      o_load_filter   <= (state == ST_FLOAD);
      o_load_idx      <= (state == ST_FLOAD) ? fidx : '0;
      o_change_filter <= (state == ST_FCHG);
      o_busy          <= (state != ST_IDLE);
      o_done          <= (state == ST_DONE);
      // Outside RUN, a beat with no read behind it is the final one.
      if (issue_c) o_data_run <= 1'b1;
      else if (o_vld && !o_rd_en && (state != ST_RUN)) o_data_run <= 1'b0;
    end
  end

  seq_delay_line #(.WIDTH(FLG_W), .DEPTH(1 + FLAG_DELAY)) u_flag_dly (
    .clk  (clk),
    .rstn (rstn),
    .din  (rd_flags),
    .dout (flags_dly)
  );

  seq_delay_line #(.WIDTH(1), .DEPTH(CAL_LAG)) u_cal_dly (
    .clk  (clk),
    .rstn (rstn),
    .din  (o_vld),
    .dout (o_cal_start)
  );

  assign o_is_first_row = flags_dly[FLG_FIRST_ROW];
  assign o_is_last_row  = flags_dly[FLG_LAST_ROW];
  assign o_is_first_col = flags_dly[FLG_FIRST_COL];
  assign o_is_last_col  = flags_dly[FLG_LAST_COL];

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench: K=3 and K=5 sequencers fed by a tagged line-buffer model.
module tb_conv_window_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned WS = 10;
  localparam int unsigned CW = 160;

  typedef struct {
    logic [CW-1:0] flat;
    logic [3:0]    flags;
  } beat_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // K=3 unit
  logic          start = 1'b0, stall = 1'b0;
  logic [WS-1:0] cw = '0, ch = '0;
  logic          rd_en, vld, fr, lr, fc, lc, lf, chg, drun, cal, busy, done;
  logic [WS-1:0] rd_row, rd_col;
  logic [3*DW-1:0] rd_data, flat;
  logic [1:0]    lidx;
  logic [3:0]    flags3;

  // K=5 unit
  logic          start5 = 1'b0;
  logic [WS-1:0] cw5 = '0, ch5 = '0;
  logic          rd_en5, vld5, fr5, lr5, fc5, lc5, lf5, chg5, drun5, cal5, busy5, done5;
  logic [WS-1:0] rd_row5, rd_col5;
  logic [5*DW-1:0] rd_data5, flat5;
  logic [1:0]    lidx5;
  logic [3:0]    flags5;

  function automatic logic [DW-1:0] word(input int r, input int c, input int j);
    return {8'(r), 8'(c), 8'(j), 8'hA5};
  endfunction

  function automatic logic [CW-1:0] lb_data(input int r, input int c);
    logic [CW-1:0] v;
    for (int j = 0; j < 5; j++) v[j*DW +: DW] = word(r, c, j);
    return v;
  endfunction

  // Expected padded window and flags for position (r,c) of a w x h frame.
  function automatic beat_t exp_beat(input int r, input int c, input int w, input int h, input int k);
    beat_t b;
    int src;
    b.flat = '0;
    for (int j = 0; j < k; j++) begin
      src = r - (k - 1) / 2 + j;
      if (src >= 0 && src < h) b.flat[j*DW +: DW] = word(r, c, j);
    end
    b.flags = {c == w - 1, c == 0, r == h - 1, r == 0};
    return b;
  endfunction

  assign rd_data  = (3*DW)'(lb_data(int'(rd_row), int'(rd_col)));
  assign rd_data5 = lb_data(int'(rd_row5), int'(rd_col5));
  assign flags3   = {lc, fc, lr, fr};
  assign flags5   = {lc5, fc5, lr5, fr5};

  conv_window_sequencer #(.K(3), .IFM_DW(DW), .W_SIZE(WS), .N_FLOAD(4), .W_FIDX(2),
                          .FLAG_DELAY(2), .CAL_LAG(3)) u_dut (
    .clk(clk), .rstn(rstn), .i_start(start), .i_cfg_width(cw), .i_cfg_height(ch),
    .i_stall(stall), .o_rd_en(rd_en), .o_rd_row(rd_row), .o_rd_col(rd_col),
    .i_rd_data(rd_data), .o_ifm_flat(flat), .o_vld(vld),
    .o_is_first_row(fr), .o_is_last_row(lr), .o_is_first_col(fc), .o_is_last_col(lc),
    .o_load_filter(lf), .o_load_idx(lidx), .o_change_filter(chg), .o_data_run(drun),
    .o_cal_start(cal), .o_busy(busy), .o_done(done)
  );

  conv_window_sequencer #(.K(5), .IFM_DW(DW), .W_SIZE(WS), .N_FLOAD(4), .W_FIDX(2),
                          .FLAG_DELAY(2), .CAL_LAG(3)) u_dut5 (
    .clk(clk), .rstn(rstn), .i_start(start5), .i_cfg_width(cw5), .i_cfg_height(ch5),
    .i_stall(1'b0), .o_rd_en(rd_en5), .o_rd_row(rd_row5), .o_rd_col(rd_col5),
    .i_rd_data(rd_data5), .o_ifm_flat(flat5), .o_vld(vld5),
    .o_is_first_row(fr5), .o_is_last_row(lr5), .o_is_first_col(fc5), .o_is_last_col(lc5),
    .o_load_filter(lf5), .o_load_idx(lidx5), .o_change_filter(chg5), .o_data_run(drun5),
    .o_cal_start(cal5), .o_busy(busy5), .o_done(done5)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  beat_t sb[$];
  beat_t sb5[$];
  int cyc = 0, beats = 0, beats5 = 0, nlf = 0, nchg = 0, ndone = 0, ndrun = 0;
  int last_rd = 0, done_cyc = 0;
  logic [31:0] lidx_hist = '0;

  // Monitor: pops the scoreboard on every o_vld; flags expected 2 cycles later, cal_start 3.
  initial begin : monitor
    logic [3:0] fp [2];
    logic [3:0] fp5 [2];
    logic [2:0] vh;
    beat_t b;
    fp[0] = '0; fp[1] = '0; fp5[0] = '0; fp5[1] = '0; vh = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        fp[0] = '0; fp[1] = '0; fp5[0] = '0; fp5[1] = '0; vh = '0;
      end else begin
        if ((fp[1] != 4'd0) || (flags3 != 4'd0)) chk("flags", int'(flags3), int'(fp[1]));
        fp[1] = fp[0];
        fp[0] = '0;
        if (vld) begin
          beats++;
          if (sb.size() == 0) chk("extra_vld", 1, 0);
          else begin
            b = sb.pop_front();
            chkw("window", CW'(flat), b.flat);
            fp[0] = b.flags;
          end
        end
        if (vh[2] || cal) chk("cal_start", int'(cal), int'(vh[2]));
        vh = {vh[1:0], vld};
        if (rd_en) last_rd = cyc;
        if (drun) ndrun++;
        if (lf) begin
          nlf++;
          lidx_hist = {lidx_hist[29:0], lidx};
        end
        if (chg) nchg++;
        if (done) begin
          ndone++;
          done_cyc = cyc;
        end
        if ((fp5[1] != 4'd0) || (flags5 != 4'd0)) chk("flags5", int'(flags5), int'(fp5[1]));
        fp5[1] = fp5[0];
        fp5[0] = '0;
        if (vld5) begin
          beats5++;
          if (sb5.size() == 0) chk("extra_vld5", 1, 0);
          else begin
            b = sb5.pop_front();
            chkw("window5", flat5, b.flat);
            fp5[0] = b.flags;
          end
        end
      end
    end
  end

  task automatic push_frame(input int w, input int h, input int k);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (k == 3) sb.push_back(exp_beat(r, c, w, h, k));
        else sb5.push_back(exp_beat(r, c, w, h, k));
  endtask

  task automatic pulse_start(input int w, input int h, output int s_cyc);
    @(posedge clk); #1;
    cw = WS'(w); ch = WS'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin : stim
    int s, b0, l0, c0, d0, r0, n0;
    bit found;
    #12;
    chkw("reset_ctl", CW'({rd_en, rd_row, rd_col, vld, flags3, lf, lidx, chg, drun, cal, busy, done}), '0);
    chkw("reset_flat", CW'(flat), '0);
    chkw("reset_ctl5", CW'({rd_en5, vld5, flags5, lf5, chg5, drun5, cal5, busy5, done5}), '0);
    @(negedge clk); rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: 4x3 clean pass
    b0 = beats; l0 = nlf; c0 = nchg; d0 = ndrun;
    push_frame(4, 3, 3);
    pulse_start(4, 3, s);
    wait_done(100);
    chk("t1_start_to_done", done_cyc - s, 25);
    chk("t1_done_after_rd", done_cyc - last_rd, 7);
    chk("t1_beats", beats - b0, 12);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_load_idx", int'(lidx_hist[7:0]), 8'h1B);
    chk("t1_nload", nlf - l0, 4);
    chk("t1_change", nchg - c0, 1);
    chk("t1_data_run", ndrun - d0, 13);

    // 2: same frame, 3-cycle stall after (1,2) is issued
    b0 = beats; d0 = ndrun;
    push_frame(4, 3, 3);
    pulse_start(4, 3, s);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rd_en && rd_row == WS'(1) && rd_col == WS'(2)) begin found = 1'b1; break; end
    end
    chk("t2_reach_1_2", int'(found), 1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold", int'({rd_en, rd_row, rd_col}), int'({1'b0, 10'd1, 10'd2}));
    end
    stall = 1'b0;
    wait_done(100);
    chk("t2_start_to_done", done_cyc - s, 28);
    chk("t2_beats", beats - b0, 12);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_data_run", ndrun - d0, 16);

    // 3: K=5, 2x2
    b0 = beats5;
    push_frame(2, 2, 5);
    @(posedge clk); #1; cw5 = WS'(2); ch5 = WS'(2); start5 = 1'b1;
    @(posedge clk); #1; start5 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done5) begin found = 1'b1; break; end
    end
    chk("t3_done5", int'(found), 1);
    #1;
    chk("t3_beats5", beats5 - b0, 4);
    chk("t3_sb5_empty", sb5.size(), 0);

    // 4: 1x1 frame
    b0 = beats;
    push_frame(1, 1, 3);
    pulse_start(1, 1, s);
    wait_done(60);
    chk("t4_start_to_done", done_cyc - s, 14);
    chk("t4_beats", beats - b0, 1);
    chk("t4_sb_empty", sb.size(), 0);

    // 5a: i_start again mid-RUN is ignored
    b0 = beats; n0 = ndone;
    push_frame(4, 3, 3);
    pulse_start(4, 3, s);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_en) begin found = 1'b1; break; end
    end
    chk("t5_run_reached", int'(found), 1);
    pulse_start(2, 2, r0);
    wait_done(100);
    repeat (10) @(negedge clk);
    #1;
    chk("t5_beats", beats - b0, 12);
    chk("t5_single_done", ndone - n0, 1);
    chk("t5_idle", int'(busy), 0);
    chk("t5_sb_empty", sb.size(), 0);

    // 5b: zero width, no beats
    b0 = beats; l0 = nlf; c0 = nchg;
    pulse_start(0, 3, s);
    wait_done(60);
    chk("t5b_start_to_done", done_cyc - s, 13);
    chk("t5b_beats", beats - b0, 0);
    chk("t5b_nload", nlf - l0, 4);
    chk("t5b_change", nchg - c0, 1);

    // 6: reset at beat 5 of a 4x3 pass
    b0 = beats;
    push_frame(4, 3, 3);
    pulse_start(4, 3, s);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (beats - b0 >= 5) break;
    end
    chk("t6_beat5", beats - b0, 5);
    #1 rstn = 1'b0;
    #1;
    chkw("t6_async_ctl", CW'({rd_en, rd_row, rd_col, vld, flags3, lf, lidx, chg, drun, cal, busy, done}), '0);
    chkw("t6_async_flat", CW'(flat), '0);
    sb.delete();
    n0 = ndone;
    repeat (3) @(negedge clk);
    rstn = 1'b1; start = 1'b1; cw = WS'(4); ch = WS'(3);
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_done", ndone - n0, 0);
    chk("t6_start_at_release_ignored", int'(busy), 0);
    b0 = beats;
    push_frame(4, 3, 3);
    pulse_start(4, 3, s);
    wait_done(100);
    chk("t6_clean_start_to_done", done_cyc - s, 25);
    chk("t6_clean_beats", beats - b0, 12);
    chk("t6_clean_sb_empty", sb.size(), 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Parametrised frame sequencer that drives one conv_pe per layer pass.
- Per pass it runs the filter-load phase, pulses change_filter, then sweeps a cfg_width × cfg_height IFM frame in raster order.
- For each output position it issues a line-buffer read, zero-pads the K-row window at the top and bottom frame edges, and emits the flattened window.
- It also emits first/last row/col flags aligned to the PE's internal pipeline, plus data_run, cal_start and done.

Parameters:
- K, 3, kernel rows in the window; odd, ≥3.
- IFM_DW, 32, bits per window row word.
- W_SIZE, 10, width of row/col counters and cfg ports.
- N_FLOAD, 4, filter-load cycles per pass.
- W_FIDX, 2, load_idx width; must satisfy 2^W_FIDX ≥ N_FLOAD.
- FLAG_DELAY, 2, extra cycles the edge flags lag the matching o_vld beat.
- CAL_LAG, 3, cycles from an o_vld beat to its o_cal_start beat.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- i_start  in  1  one-cycle pass request; honoured only in IDLE
- i_cfg_width  in  W_SIZE  frame columns; sampled at i_start
- i_cfg_height  in  W_SIZE  frame rows; sampled at i_start
- i_stall  in  1  holds sweep advance while high
- o_rd_en  out  1  line-buffer read strobe
- o_rd_row  out  W_SIZE  centre row of requested window
- o_rd_col  out  W_SIZE  requested column
- i_rd_data  in  K*IFM_DW  rows centre-(K-1)/2 .. centre+(K-1)/2, slot 0 in LSBs; valid 1 cycle after o_rd_en
- o_ifm_flat  out  K*IFM_DW  padded window, same packing
- o_vld  out  1  o_ifm_flat valid
- o_is_first_row / o_is_last_row / o_is_first_col / o_is_last_col  out  1 each  edge flags
- o_load_filter  out  1  filter-load strobe
- o_load_idx  out  W_FIDX  filter word index
- o_change_filter  out  1  one-cycle filter swap pulse
- o_data_run  out  1  high from first o_rd_en to last o_vld
- o_cal_start  out  1  o_vld delayed CAL_LAG
- o_busy  out  1  state ≠ IDLE
- o_done  out  1  one-cycle end-of-pass pulse

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0; all delay lines cleared. Reset asserted mid-pass aborts immediately, with no o_done.
- FSM states and transitions:
  - IDLE → FLOAD on i_start; width and height are captured.
  - FLOAD lasts N_FLOAD cycles. o_load_filter=1 and o_load_idx=0..N_FLOAD-1 on consecutive cycles.
  - FCHG lasts 1 cycle with o_change_filter=1. FCHG → RUN, or → DRAIN if width==0 or height==0 (no beats issued).
  - RUN: each non-stalled cycle issues o_rd_en=1 with o_rd_row=r, o_rd_col=c.
    - Order is c 0..W-1 within r 0..H-1.
    - After (H-1, W-1) is issued → DRAIN.
    - When i_stall=1: no issue, counters hold, and a bubble enters the delay lines.
  - DRAIN lasts exactly 1+CAL_LAG+FLAG_DELAY cycles; i_stall is ignored.
  - DONE lasts 1 cycle with o_done=1, then → IDLE.
- i_start outside IDLE is ignored. i_start asserted in the same cycle as reset release is ignored.
- Read latency: o_vld and o_ifm_flat are registered 1 cycle after o_rd_en.
- Padding: slot j represents row r-(K-1)/2+j. The slot is forced to zero if that row is <0 or ≥H; otherwise it passes i_rd_data unchanged.
- Edge flags per beat: first_row=(r==0), last_row=(r==H-1), first_col=(c==0), last_col=(c==W-1). They appear FLAG_DELAY cycles after that beat's o_vld. Flags are 0 on bubble slots.
- H==1 sets first_row and last_row together; W==1 sets first_col and last_col together.
- o_cal_start asserts CAL_LAG cycles after each o_vld beat, including bubbles, i.e. it is a pure delay.
- Delay lines shift every cycle in every state.
- o_data_run rises with the first RUN o_rd_en and falls the cycle after the last o_vld.
- Counters: c wraps to 0 and r increments when c==W-1. No state exists beyond H*W beats.

Decomposition:
- Package conv_seq_pkg holds:
  - FSM state encoding (IDLE, FLOAD, FCHG, RUN, DRAIN, DONE);
  - flag-bundle bit indices;
  - the K-half constant (K-1)/2.
- One sub-module, seq_delay_line (parametrised WIDTH and DEPTH, async reset to 0). It is used for the flag bundle (depth 1+FLAG_DELAY) and for cal_start (depth CAL_LAG).

Test Plan:
1. W=4, H=3, K=3, no stall:
   - o_load_idx 0,1,2,3 then one o_change_filter.
   - 12 o_vld beats.
   - Beats 0–3: slot0=0. Beats 8–11: slot2=0.
   - first_col on beats 0,4,8 and last_col on 3,7,11, each at +2 cycles.
   - o_done exactly 7 cycles after the last o_rd_en.
2. Same frame, i_stall high for 3 cycles at r=1,c=2:
   - o_rd_row/col hold at (1,2).
   - Three-cycle gap in o_vld and o_cal_start.
   - Flag sequence unchanged; o_done delayed 3 cycles.
3. K=5, W=2, H=2:
   - Beat (0,*): slots 0,1,4 zero.
   - Beat (1,*): slots 0,3,4 zero.
   - All four flags set on both rows as appropriate.
4. W=1, H=1:
   - Single beat with all four flags =1.
   - slot0 and slot2 zero, slot1 = i_rd_data slot1.
5. i_start pulsed again during RUN → ignored, beat count still W*H. Separately, width=0 → FLOAD, FCHG, then o_done with zero o_vld.
6. rstn low at beat 5 of a 4×3 pass:
   - All outputs 0 asynchronously; no o_done.
   - A new i_start afterwards completes a full clean pass.
